// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and helpers for the MEM-stage load/store engine:
//            access opcodes, FSM state encoding, exception codes and opcode
//            decode functions (size, store, signedness, legality).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWU = 4'd5,
        LD  = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9,
        SD  = 4'd10
    } mem_op_e;

    // FSM state encoding
    typedef logic [2:0] mau_state_e;
    localparam mau_state_e S_IDLE  = 3'd0;
    localparam mau_state_e S_REQ   = 3'd1;
    localparam mau_state_e S_RESP  = 3'd2;
    localparam mau_state_e S_EXC   = 3'd3;
    localparam mau_state_e S_DRAIN = 3'd4;

    // Exception codes (MIPS ExcCode numbering)
    localparam logic [4:0] EXC_ADEL   = 5'd4;
    localparam logic [4:0] EXC_ADES   = 5'd5;
    localparam logic [4:0] EXC_BUSERR = 5'd7;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            LB, LBU, SB: op_size = 2'd0;
            LH, LHU, SH: op_size = 2'd1;
            LW, LWU, SW: op_size = 2'd2;
            default:     op_size = 2'd3;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        op_is_signed = (op == LB) || (op == LH) || (op == LW);
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        op_is_legal = (op <= SD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational lane logic. Request side: byte enables, store
//            data lane shift, alignment and no-op detection for the op being
//            issued. Response side: extracts the addressed bytes from the
//            read beat and sign/zero extends them.
// Ports    : i_req_op/i_req_off/i_wdata -> o_aligned, o_nop, o_be, o_wdata
//            i_rsp_op/i_rsp_off/i_rdata -> o_ld_data
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [3:0]        i_req_op,
    input  logic [OFF_W-1:0]  i_req_off,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_aligned,
    output logic              o_nop,
    output logic [BYTES-1:0]  o_be,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [3:0]        i_rsp_op,
    input  logic [OFF_W-1:0]  i_rsp_off,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);

    localparam int C_MAX_SZ = OFF_W;   // log2 of the widest access the bus carries

    logic [1:0]        w_req_sz;
    logic [1:0]        w_rsp_sz;
    logic [DATA_W-1:0] w_st_src;
    logic [DATA_W-1:0] w_shifted;
    logic              w_sign;

    assign w_req_sz = op_size(i_req_op);
    assign w_rsp_sz = op_size(i_rsp_op);

    // Accesses wider than the bus (LD/SD on a 32-bit build) and undefined
    // opcodes complete without touching memory.
    assign o_nop     = !op_is_legal(i_req_op) || (int'(w_req_sz) > C_MAX_SZ);
    assign o_aligned = (i_req_off & OFF_W'((1 << w_req_sz) - 1)) == '0;

    always_comb begin
        o_be     = '0;
        w_st_src = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < (1 << w_req_sz))
                w_st_src[8*i +: 8] = i_wdata[8*i +: 8];
            if ((i >= int'(i_req_off)) && (i < int'(i_req_off) + (1 << w_req_sz)))
                o_be[i] = 1'b1;
        end
        o_wdata = w_st_src << {i_req_off, 3'b000};
    end

    assign w_shifted = i_rdata >> {i_rsp_off, 3'b000};

    // Sign bit picked with constant indices so the select width stays exact.
    always_comb begin
        w_sign    = 1'b0;
        o_ld_data = '0;
        for (int b = 0; b < DATA_W; b++) begin
            if (op_is_signed(i_rsp_op) && (b == 8 * (1 << w_rsp_sz) - 1))
                w_sign = w_shifted[b];
        end
        for (int b = 0; b < DATA_W; b++) begin
            o_ld_data[b] = (b < 8 * (1 << w_rsp_sz)) ? w_shifted[b] : w_sign;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store engine. Decodes the access, checks
//            alignment, drives a req/ack data-memory port with timeout,
//            returns extended load data, and raises AdEL/AdES/bus-error
//            pulses. Supports pipeline stall and flush.
// Ports    : clk, rst_n (sync, active low)
//            op_valid/op_code/addr/wdata/flush  - from EX/MEM register
//            stall, ld_valid/ld_data, st_done   - to pipeline
//            exc_adel/exc_ades/exc_buserr, bad_vaddr - exception report
//            mem_req/we/addr/be/wdata, mem_ack/rdata - data-memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    input  logic [3:0]              op_code,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    flush,
    output logic                    stall,
    output logic                    ld_valid,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    st_done,
    output logic                    exc_adel,
    output logic                    exc_ades,
    output logic                    exc_buserr,
    output logic [ADDR_W-1:0]       bad_vaddr,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W/8-1:0]     mem_be,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int C_BYTES = DATA_W / 8;
    localparam int C_OFF_W = $clog2(C_BYTES);
    localparam int C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mau_state_e          r_state;
    mau_state_e          w_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [4:0]          r_exc_code;
    logic                r_resp_ld;
    logic                r_resp_st;
    logic [DATA_W-1:0]   r_ld_data;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [C_BYTES-1:0]  r_mem_be;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_aligned;
    logic                w_nop;
    logic [C_BYTES-1:0]  w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_store;
    logic                w_timeout;
    logic                w_take;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_req_op  (op_code),
        .i_req_off (addr[C_OFF_W-1:0]),
        .i_wdata   (wdata),
        .o_aligned (w_aligned),
        .o_nop     (w_nop),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_rsp_op  (r_op),
        .i_rsp_off (r_addr[C_OFF_W-1:0]),
        .i_rdata   (mem_rdata),
        .o_ld_data (w_ld_data)
    );

    assign w_store   = op_is_store(op_code);
    assign w_take    = op_valid && !flush;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_take;
                if (w_take) begin
                    if (w_nop)           w_next = S_RESP;
                    else if (!w_aligned) w_next = S_EXC;
                    else                 w_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                // Flush coinciding with ack retires the bus cycle and drops the result.
                if (mem_ack)        w_next = flush ? S_IDLE : S_RESP;
                else if (flush)     w_next = S_DRAIN;
                else if (w_timeout) w_next = S_EXC;
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (mem_ack) w_next = S_IDLE;
            end
            S_RESP:  w_next = S_IDLE;
            S_EXC:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_exc_code  <= '0;
            r_resp_ld   <= 1'b0;
            r_resp_st   <= 1'b0;
            r_ld_data   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_op      <= op_code;
                        r_addr    <= addr;
                        r_resp_ld <= 1'b0;
                        r_resp_st <= 1'b0;
                        if (!w_nop && !w_aligned)
                            r_exc_code <= w_store ? EXC_ADES : EXC_ADEL;
                        if (!w_nop && w_aligned) begin
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_store;
                            r_mem_addr  <= {addr[ADDR_W-1:C_OFF_W], {C_OFF_W{1'b0}}};
                            // Loads read the whole beat; lanes are picked on return.
                            r_mem_be    <= w_store ? w_be : '0;
                            r_mem_wdata <= w_store ? w_wdata : '0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                        if (!flush) begin
                            r_resp_ld <= !r_mem_we;
                            r_resp_st <= r_mem_we;
                        end
                        if (!r_mem_we) r_ld_data <= w_ld_data;
                    end else if (!flush && w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                        r_exc_code  <= EXC_BUSERR;
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_valid   = (r_state == S_RESP) && r_resp_ld;
    assign st_done    = (r_state == S_RESP) && r_resp_st;
    assign exc_adel   = (r_state == S_EXC) && (r_exc_code == EXC_ADEL);
    assign exc_ades   = (r_state == S_EXC) && (r_exc_code == EXC_ADES);
    assign exc_buserr = (r_state == S_EXC) && (r_exc_code == EXC_BUSERR);
    assign bad_vaddr  = (r_state == S_EXC) ? r_addr : '0;
    assign ld_data    = r_ld_data;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: a 32-bit instance
//            (TIMEOUT=4) driven from a vector table with a result scoreboard,
//            and a 64-bit instance exercised by directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int K_LD = 0, K_ST = 1, K_ADEL = 2, K_ADES = 3, K_BUS = 4, K_NOP = 5;

    typedef struct {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [3:0]  be;
        logic [31:0] ewdata;
        int          kind;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst_n = 1'b0, op_valid = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [3:0]  op_code = '0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        stall, ld_valid, st_done, exc_adel, exc_ades, exc_buserr, mem_req, mem_we;
    logic [31:0] ld_data, bad_vaddr, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .addr(addr),
        .wdata(wdata), .flush(flush), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .st_done(st_done), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_buserr(exc_buserr),
        .bad_vaddr(bad_vaddr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // 64-bit instance
    logic        d6_rst_n = 1'b0, d6_op_valid = 1'b0, d6_flush = 1'b0, d6_mem_ack = 1'b0;
    logic [3:0]  d6_op_code = '0;
    logic [31:0] d6_addr = '0;
    logic [63:0] d6_wdata = '0, d6_mem_rdata = '0;
    logic        d6_stall, d6_ld_valid, d6_st_done, d6_exc_adel, d6_exc_ades, d6_exc_buserr;
    logic        d6_mem_req, d6_mem_we;
    logic [63:0] d6_ld_data, d6_mem_wdata;
    logic [31:0] d6_bad_vaddr, d6_mem_addr;
    logic [7:0]  d6_mem_be;

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .rst_n(d6_rst_n), .op_valid(d6_op_valid), .op_code(d6_op_code),
        .addr(d6_addr), .wdata(d6_wdata), .flush(d6_flush), .stall(d6_stall),
        .ld_valid(d6_ld_valid), .ld_data(d6_ld_data), .st_done(d6_st_done),
        .exc_adel(d6_exc_adel), .exc_ades(d6_exc_ades), .exc_buserr(d6_exc_buserr),
        .bad_vaddr(d6_bad_vaddr), .mem_req(d6_mem_req), .mem_we(d6_mem_we),
        .mem_addr(d6_mem_addr), .mem_be(d6_mem_be), .mem_wdata(d6_mem_wdata),
        .mem_ack(d6_mem_ack), .mem_rdata(d6_mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every result pulse of the 32-bit unit must match the oldest expectation.
    always @(negedge clk) begin : p_mon
        logic [4:0]  p;
        int          k;
        logic [31:0] d;
        exp_t        e;
        if (rst_n) begin
            p = {ld_valid, st_done, exc_adel, exc_ades, exc_buserr};
            if ($countones(p) > 1) begin
                chk("one_pulse", 64'($countones(p)), 64'd1);
            end else if (p != '0) begin
                k = ld_valid ? K_LD : st_done ? K_ST : exc_adel ? K_ADEL : exc_ades ? K_ADES : K_BUS;
                d = ld_valid ? ld_data : (st_done ? 32'h0 : bad_vaddr);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none", k);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 64'(k), 64'(e.kind));
                    chk("pulse_data", 64'(d), 64'(e.data));
                    chk("pulse_stall", 64'(stall), 64'd0);
                end
            end
        end
    end

    task automatic run32(input vec_t v);
        @(negedge clk);
        op_valid = 1'b1; op_code = v.op; addr = v.addr; wdata = v.wdata;
        #1 chk("stall_idle", 64'(stall), 64'd1);
        if (v.kind != K_NOP) sb.push_back('{v.kind, v.data});
        @(posedge clk);
        #1 op_valid = 1'b0; op_code = '0; addr = '0; wdata = '0;
        @(negedge clk);
        if (v.kind == K_LD || v.kind == K_ST) begin
            chk("req_up", 64'(mem_req), 64'd1);
            chk("req_we", 64'(mem_we), 64'(v.kind == K_ST));
            chk("req_addr", 64'(mem_addr), 64'(v.addr & 32'hFFFF_FFFC));
            chk("req_stall", 64'(stall), 64'd1);
            if (v.kind == K_ST) begin
                chk("req_be", 64'(mem_be), 64'(v.be));
                chk("req_wdata", 64'(mem_wdata), 64'(v.ewdata));
            end
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                chk("req_hold", 64'({mem_req, mem_addr}), 64'({1'b1, v.addr & 32'hFFFF_FFFC}));
            end
            mem_ack = 1'b1; mem_rdata = v.rdata;
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_rdata = '0;
            @(negedge clk);
            chk("done_pulse", 64'({ld_valid, st_done}), (v.kind == K_LD) ? 64'd2 : 64'd1);
            chk("req_dropped", 64'(mem_req), 64'd0);
        end else if (v.kind == K_NOP) begin
            chk("nop_no_req", 64'(mem_req), 64'd0);
            chk("nop_quiet", 64'({ld_valid, st_done, exc_adel, exc_ades, exc_buserr, stall}), 64'd0);
        end else begin
            chk("exc_no_req", 64'(mem_req), 64'd0);
            chk("exc_now", 64'({exc_adel, exc_ades}), (v.kind == K_ADEL) ? 64'd2 : 64'd1);
        end
        @(posedge clk);
    endtask

    task automatic run64(input mem_op_e op, input logic [31:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [7:0] ebe, input logic [63:0] ewd,
                         input logic [4:0] epulse, input logic [63:0] edata);
        @(negedge clk);
        d6_op_valid = 1'b1; d6_op_code = op; d6_addr = a; d6_wdata = wd;
        @(posedge clk);
        #1 d6_op_valid = 1'b0;
        if (epulse[4] || epulse[3]) begin
            @(negedge clk);
            chk("d6_req_addr", 64'(d6_mem_addr), 64'(a & 32'hFFFF_FFF8));
            chk("d6_req_up", 64'(d6_mem_req), 64'd1);
            if (epulse[3]) begin
                chk("d6_be", 64'(d6_mem_be), 64'(ebe));
                chk("d6_wdata", d6_mem_wdata, ewd);
            end
            d6_mem_ack = 1'b1; d6_mem_rdata = rd;
            @(posedge clk);
            #1 d6_mem_ack = 1'b0; d6_mem_rdata = '0;
        end
        @(negedge clk);
        chk("d6_pulse", 64'({d6_ld_valid, d6_st_done, d6_exc_adel, d6_exc_ades, d6_exc_buserr}),
            64'(epulse));
        if (epulse[4]) chk("d6_ld_data", d6_ld_data, edata);
        if (epulse[2] || epulse[1]) chk("d6_bad_vaddr", 64'(d6_bad_vaddr), edata);
        @(posedge clk);
    endtask

    vec_t vecs[16];

    initial begin
        int cnt;
        int seen;

        vecs[0]  = '{SB,  32'h1003, 32'h1234_56AB, 32'h0,          0, 4'b1000, 32'hAB00_0000, K_ST,   32'h0};
        vecs[1]  = '{LH,  32'h2002, 32'h0,         32'h8001_0000,  1, 4'b0000, 32'h0,         K_LD,   32'hFFFF_8001};
        vecs[2]  = '{LHU, 32'h2002, 32'h0,         32'h8001_0000,  0, 4'b0000, 32'h0,         K_LD,   32'h0000_8001};
        vecs[3]  = '{SW,  32'h3002, 32'hDEAD_BEEF, 32'h0,          0, 4'b0000, 32'h0,         K_ADES, 32'h3002};
        vecs[4]  = '{LH,  32'h3001, 32'h0,         32'h0,          0, 4'b0000, 32'h0,         K_ADEL, 32'h3001};
        vecs[5]  = '{LB,  32'h4001, 32'h0,         32'h1234_8078,  2, 4'b0000, 32'h0,         K_LD,   32'hFFFF_FF80};
        vecs[6]  = '{LBU, 32'h4001, 32'h0,         32'h1234_8078,  0, 4'b0000, 32'h0,         K_LD,   32'h0000_0080};
        vecs[7]  = '{LW,  32'h5000, 32'h0,         32'hDEAD_BEEF,  0, 4'b0000, 32'h0,         K_LD,   32'hDEAD_BEEF};
        vecs[8]  = '{SH,  32'h6002, 32'hCAFE_1234, 32'h0,          1, 4'b1100, 32'h1234_0000, K_ST,   32'h0};
        vecs[9]  = '{SW,  32'h7000, 32'h89AB_CDEF, 32'h0,          0, 4'b1111, 32'h89AB_CDEF, K_ST,   32'h0};
        vecs[10] = '{LW,  32'h5001, 32'h0,         32'h0,          0, 4'b0000, 32'h0,         K_ADEL, 32'h5001};
        vecs[11] = '{SB,  32'h8000, 32'h0000_00FF, 32'h0,          0, 4'b0001, 32'h0000_00FF, K_ST,   32'h0};
        vecs[12] = '{LD,  32'h9000, 32'h0,         32'h0,          0, 4'b0000, 32'h0,         K_NOP,  32'h0};
        vecs[13] = '{LWU, 32'h5004, 32'h0,         32'h8000_0000,  0, 4'b0000, 32'h0,         K_LD,   32'h8000_0000};
        vecs[14] = '{LH,  32'h2000, 32'h0,         32'h0001_FFFE,  0, 4'b0000, 32'h0,         K_LD,   32'hFFFF_FFFE};
        vecs[15] = '{SH,  32'h6001, 32'h0000_1234, 32'h0,          0, 4'b0000, 32'h0,         K_ADES, 32'h6001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({stall, ld_valid, st_done, exc_adel, exc_ades, exc_buserr, mem_req, mem_we}), 64'd0);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'd0);
        chk("rst_be_data", {28'd0, mem_be, ld_data}, 64'd0);
        chk("rst_vaddr", 64'(bad_vaddr), 64'd0);
        rst_n = 1'b1; d6_rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 16; i++) run32(vecs[i]);

        // Bus timeout: ack never arrives
        @(negedge clk);
        op_valid = 1'b1; op_code = LW; addr = 32'h5000;
        sb.push_back('{K_BUS, 32'h5000});
        @(posedge clk);
        #1 op_valid = 1'b0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (exc_buserr) begin
                seen = 1;
                chk("buserr_stall", 64'(stall), 64'd0);
            end
        end
        chk("buserr_seen", 64'(seen), 64'd1);
        chk("timeout_req_cycles", 64'(cnt), 64'd4);
        @(posedge clk);

        // Flush in the second REQ cycle, ack three cycles later
        @(negedge clk);
        op_valid = 1'b1; op_code = LW; addr = 32'h5008;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("flush_req1_stall", 64'(stall), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_hold", 64'({mem_req, stall, ld_valid}), 64'd6);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("drain_done", 64'({mem_req, stall, ld_valid}), 64'd0);
        @(negedge clk);
        chk("drain_quiet", 64'(ld_valid), 64'd0);

        // Flush while idle blocks a new access
        @(negedge clk);
        op_valid = 1'b1; op_code = SW; addr = 32'hA000; flush = 1'b1;
        #1 chk("flush_idle_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 op_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_req", 64'({mem_req, stall}), 64'd0);

        // 64-bit data path
        run64(LD, 32'h08, 64'h0, 64'h8000_0000_1234_5678, 8'h00, 64'h0, 5'b10000, 64'h8000_0000_1234_5678);
        run64(LW, 32'h0C, 64'h0, 64'h8000_0000_0000_0000, 8'h00, 64'h0, 5'b10000, 64'hFFFF_FFFF_8000_0000);
        run64(LWU, 32'h0C, 64'h0, 64'h8000_0000_0000_0000, 8'h00, 64'h0, 5'b10000, 64'h0000_0000_8000_0000);
        run64(SD, 32'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 5'b01000, 64'h0);
        run64(SW, 32'h0C, 64'hAABB_CCDD_1122_3344, 64'h0, 8'hF0, 64'h1122_3344_0000_0000, 5'b01000, 64'h0);
        run64(LB, 32'h0F, 64'h0, 64'hF000_0000_0000_0000, 8'h00, 64'h0, 5'b10000, 64'hFFFF_FFFF_FFFF_FFF0);
        run64(LD, 32'h0C, 64'h0, 64'h0, 8'h00, 64'h0, 5'b00100, 64'h0C);
        run64(SH, 32'h0F, 64'h0, 64'h0, 8'h00, 64'h0, 5'b00010, 64'h0F);

        // Reset while a request is outstanding
        @(negedge clk);
        d6_op_valid = 1'b1; d6_op_code = LW; d6_addr = 32'h10;
        @(posedge clk);
        #1 d6_op_valid = 1'b0;
        @(negedge clk);
        chk("d6_req_before_rst", 64'(d6_mem_req), 64'd1);
        d6_rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("d6_req_after_rst", 64'({d6_mem_req, d6_stall}), 64'd0);
        d6_rst_n = 1'b1;
        @(posedge clk);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
